seq_serializer: RTL and testbench
=================================

SEQ_SERIALIZER -- requirements
Module: seq_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, sets the parallel word width (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1; when 1 the serializer emits bit DATA_WIDTH-1 first, when 0 it emits bit 0 first.
REQ-003 Parameter IDLE_LEVEL, default 0, sets the serial_out value whenever no bit is being presented.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 data_in  input  DATA_WIDTH  parallel word to serialize.
REQ-007 load  input  1  the word on data_in is valid this cycle.
REQ-008 ready  output  1  the block can accept a word this cycle.
REQ-009 serial_out  output  1  serial bit stream, one bit per clock; feeds the downstream sequence detector input i.
REQ-010 serial_valid  output  1  serial_out carries a data bit this cycle.
REQ-011 last_bit  output  1  high in the same cycle the final bit of a word is presented.

Function
REQ-012 The handshake completes (word accepted) in a cycle where load=1 and ready=1; load while ready=0 has no effect and the word is dropped.
REQ-013 ready shall equal NOT hold_full, where hold_full is the one-entry holding register occupancy flag.
REQ-014 The FSM has states IDLE and SHIFT.
REQ-015 A word accepted in cycle N while in IDLE loads the shift register; its first bit appears on serial_out with serial_valid=1 in cycle N+1; the last bit appears in cycle N+DATA_WIDTH.
REQ-016 In SHIFT, serial_out, serial_valid and last_bit shall be registered outputs; bit counter counts 0..DATA_WIDTH-1, and last_bit=1 when count=DATA_WIDTH-1.
REQ-017 SHIFT to SHIFT at last bit: when last_bit=1 and either hold_full=1 or a word is accepted that cycle, the next word's first bit appears in the next cycle with no gap; the held word takes priority and the newly accepted word then enters the holding register.
REQ-018 SHIFT to IDLE: when last_bit=1, hold_full=0 and no word is accepted, the next cycle has serial_valid=0 and serial_out=IDLE_LEVEL.
REQ-019 A word accepted in SHIFT at a count other than last goes to the holding register; hold_full sets the next cycle.
REQ-020 hold_full clears in the cycle its word moves to the shift register, unless a new word is accepted in that same cycle.
REQ-021 Bit order follows MSB_FIRST; the shift register shifts toward the output end, filling with IDLE_LEVEL.
REQ-022 In IDLE: serial_valid=0, last_bit=0, serial_out=IDLE_LEVEL.

Reset
REQ-023 While rst=1: state=IDLE, bit count=0, hold_full=0, shift and holding registers=0, serial_out=IDLE_LEVEL, serial_valid=0, last_bit=0, ready=1.
REQ-024 rst asserted mid-word aborts immediately; both the partial and the held words are discarded, and no bit is emitted after rst is released until a new load is accepted.

Structure
REQ-025 A shared package seq_pkg shall hold the state enum typedef (IDLE, SHIFT) and the default DATA_WIDTH constant.
REQ-026 The bit counter shall be a sub-module bit_counter, parameterized width, with clear, count_enable and rollover_flag.
REQ-027 The remaining state (FSM, shift register, holding register) shall live in seq_serializer.

Verification
REQ-028 Single word: with MSB_FIRST=1, load 8'hD0 in cycle N from IDLE -> serial_out=1,1,0,1,0,0,0,0 in cycles N+1..N+8, serial_valid high for exactly those 8 cycles, last_bit high in N+8; the downstream detector's output asserts after the 4th bit.
REQ-029 Back-to-back: load held high with 8'hA5 then 8'h3C -> 16 contiguous serial_valid cycles (10100101 00111100); ready=0 while 8'h3C is held; no idle cycle between the words.
REQ-030 Load on last bit: 8'hFF accepted in cycle N, 8'h00 accepted exactly in cycle N+8 -> the 8'h00 bits occupy N+9..N+16 with no gap, and hold_full never sets.
REQ-031 Overflow: word in shift, hold full, load=1 with 8'h77 -> 8'h77 is never emitted; the stream carries only the two accepted words.
REQ-032 Reset mid-word: rst pulsed during the 3rd bit of 8'hD0 with 8'h12 held -> outputs reach their reset values asynchronously, ready=1, and no 8'hD0 or 8'h12 bits are emitted after rst is released.
REQ-033 LSB first: with MSB_FIRST=0 and IDLE_LEVEL=1, load 8'h0B -> 1,1,0,1,0,0,0,0 emitted, and serial_out=1 when idle.

Source files
------------

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pkg
//  Description : Shared types and constants for the sequence serializer:
//                FSM state encoding, default word width, counter sizing.
//  Revision    : 1.0  initial release
// ============================================================================
package seq_pkg;

    // Default parallel word width.
    localparam int DEFAULT_DATA_WIDTH = 8;

    // Serializer FSM states, explicit 1-bit encoding.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bits needed by a counter that must reach w-1 (w >= 2).
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage : seq_pkg
`default_nettype wire

// File: rtl/seq_serializer_bit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bit_counter
//  Description : Wrapping up-counter 0..MAX_COUNT with synchronous clear,
//                count enable and a terminal-count (rollover) flag.
//  Revision    : 1.0  initial release
// ============================================================================
module bit_counter #(
    parameter int WIDTH     = 3,
    parameter int MAX_COUNT = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_count_enable,
    output logic o_rollover_flag
);

    localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] r_count;

    // Count register: clear wins over enable; wraps to zero after MAX_COUNT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count_enable) begin
            r_count <= (r_count == c_max) ? '0 : r_count + 1'b1;
        end
    end

    // Flag the terminal count; it is a decode of the count register only.
    always_comb begin
        o_rollover_flag = (r_count == c_max);
    end

endmodule : bit_counter
`default_nettype wire

// File: rtl/seq_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : seq_serializer
//  Description : Parallel-to-serial converter with a one-entry holding
//                register so consecutive words stream with no idle gap.
//                One bit per clock, selectable bit order and idle level.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_serializer
    import seq_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  load,
    output logic                  ready,
    output logic                  serial_out,
    output logic                  serial_valid,
    output logic                  last_bit
);

    // Bit position of the shift register that drives serial_out.
    localparam int c_out_idx = MSB_FIRST ? DATA_WIDTH - 1 : 0;
    localparam int c_cnt_w   = cnt_width(DATA_WIDTH);

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [DATA_WIDTH-1:0] w_hold_next;
    logic                  r_hold_full;
    logic                  w_hold_full_next;
    logic                  r_sout;
    logic                  w_sout_next;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_rollover;
    logic                  w_cnt_clear;
    logic                  w_cnt_en;

    // Handshake: a word is taken only when the holding slot is free.
    always_comb begin
        w_accept = load && !r_hold_full;
    end

    // Bit counter runs only while shifting; held at zero in IDLE.
    always_comb begin
        w_cnt_clear = (r_state == IDLE);
        w_cnt_en    = (r_state == SHIFT);
    end

    bit_counter #(
        .WIDTH     (c_cnt_w),
        .MAX_COUNT (DATA_WIDTH - 1)
    ) u_bit_counter (
        .clk             (clk),
        .rst             (rst),
        .i_clear         (w_cnt_clear),
        .i_count_enable  (w_cnt_en),
        .o_rollover_flag (w_rollover)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state: leave SHIFT only when the last bit goes out with nothing queued.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last && !r_hold_full && !w_accept) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // FSM outputs; serial_out itself comes straight from a flop.
    always_comb begin
        ready        = !r_hold_full;
        serial_valid = (r_state == SHIFT);
        w_last       = (r_state == SHIFT) && w_rollover;
        last_bit     = w_last;
        serial_out   = r_sout;
    end

    // Shift toward the output end, back-filling with the idle level.
    always_comb begin
        if (MSB_FIRST) begin
            w_shifted = {r_shift[DATA_WIDTH-2:0], IDLE_LEVEL};
        end else begin
            w_shifted = {IDLE_LEVEL, r_shift[DATA_WIDTH-1:1]};
        end
    end

    // Datapath next values: shift register, holding register and its flag.
    always_comb begin
        w_shift_next     = r_shift;
        w_hold_next      = r_hold;
        w_hold_full_next = r_hold_full;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_shift_next = data_in;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    if (r_hold_full) begin
                        // Held word goes first; a same-cycle accept refills the slot.
                        w_shift_next     = r_hold;
                        w_hold_full_next = w_accept;
                        if (w_accept) begin
                            w_hold_next = data_in;
                        end
                    end else if (w_accept) begin
                        w_shift_next = data_in;
                    end else begin
                        w_shift_next = w_shifted;
                    end
                end else begin
                    w_shift_next = w_shifted;
                    if (w_accept) begin
                        w_hold_next      = data_in;
                        w_hold_full_next = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        w_sout_next = (w_next_state == SHIFT) ? w_shift_next[c_out_idx] : IDLE_LEVEL;
    end

    // Datapath registers, including the registered serial output bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_sout      <= IDLE_LEVEL;
        end else begin
            r_shift     <= w_shift_next;
            r_hold      <= w_hold_next;
            r_hold_full <= w_hold_full_next;
            r_sout      <= w_sout_next;
        end
    end

endmodule : seq_serializer
`default_nettype wire

// File: tb/tb_seq_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_serializer
//  Description : Self-checking bench for seq_serializer. Instance 0 uses the
//                defaults (MSB first, idle 0); instance 1 is LSB first, idle 1.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic       load0 = 1'b0;
    logic       load1 = 1'b0;
    wire        rdy0, so0, sv0, lb0;
    wire        rdy1, so1, sv1, lb1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .data_in(data0), .load(load0),
        .ready(rdy0), .serial_out(so0), .serial_valid(sv0), .last_bit(lb0)
    );

    seq_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .data_in(data1), .load(load1),
        .ready(rdy1), .serial_out(so1), .serial_valid(sv1), .last_bit(lb1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: per instance, a list of up to two accepted words (head is being
    // emitted) and the index of the head bit currently presented.
    int         mcnt[2];
    int         mpos[2];
    logic [7:0] mw[2][2];

    function automatic logic mbit(input int i);
        if (mcnt[i] == 0) return (i == 1);
        if (i == 0) return mw[i][0][7 - mpos[i]];
        return mw[i][0][mpos[i]];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt[0] = 0; mcnt[1] = 0;
            mpos[0] = 0; mpos[1] = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic       ld;
                logic [7:0] d;
                logic       acc;
                ld  = (i == 0) ? load0 : load1;
                d   = (i == 0) ? data0 : data1;
                acc = ld && (mcnt[i] < 2);
                if (mcnt[i] > 0) begin
                    mpos[i]++;
                    if (mpos[i] == 8) begin
                        mw[i][0] = mw[i][1];
                        mcnt[i]--;
                        mpos[i] = 0;
                    end
                end
                if (acc) begin
                    mw[i][mcnt[i]] = d;
                    mcnt[i]++;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("m0_ready", rdy0, mcnt[0] < 2);
        chk("m0_valid", sv0,  mcnt[0] > 0);
        chk("m0_last",  lb0,  (mcnt[0] > 0) && (mpos[0] == 7));
        chk("m0_sout",  so0,  mbit(0));
        chk("m1_ready", rdy1, mcnt[1] < 2);
        chk("m1_valid", sv1,  mcnt[1] > 0);
        chk("m1_last",  lb1,  (mcnt[1] > 0) && (mpos[1] == 7));
        chk("m1_sout",  so1,  mbit(1));
    end

    // Stream logs of emitted bits, for the literal per-scenario checks.
    logic [31:0] log0, log1;
    int          nv0, nv1, nrl0;

    always @(negedge clk) begin
        if (sv0) begin log0 = {log0[30:0], so0}; nv0++; end
        if (sv1) begin log1 = {log1[30:0], so1}; nv1++; end
        if (!rdy0) nrl0++;
    end

    task automatic clr();
        log0 = '0; log1 = '0; nv0 = 0; nv1 = 0; nrl0 = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] e;
        clr();
        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_ready0", rdy0, 1);
        chk("rst_valid0", sv0, 0);
        chk("rst_last0",  lb0, 0);
        chk("rst_sout0",  so0, 0);
        chk("rst_sout1",  so1, 1);
        #1 rst = 1'b0;

        // Single word 0xD0, MSB first.
        @(negedge clk); #1 clr(); data0 = 8'hD0; load0 = 1'b1;
        e = 8'b1101_0000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("d0_bit",   so0, e[7-k]);
            chk("d0_valid", sv0, 1);
            chk("d0_last",  lb0, k == 7);
            if (k == 0) begin #1 load0 = 1'b0; end
        end
        @(negedge clk);
        chk("d0_after_valid", sv0, 0);
        chk("d0_after_sout",  so0, 0);

        // Back-to-back A5 then 3C.
        @(negedge clk); #1 clr(); data0 = 8'hA5; load0 = 1'b1;
        @(negedge clk); #1 data0 = 8'h3C;
        @(negedge clk);
        chk("b2b_ready_held", rdy0, 0);
        #1 load0 = 1'b0;
        repeat (20) @(negedge clk);
        chk("b2b_stream", log0[15:0], 16'hA53C);
        chk("b2b_count",  nv0, 16);

        // FF then 00 accepted exactly on FF's last bit.
        @(negedge clk); #1 clr(); data0 = 8'hFF; load0 = 1'b1;
        @(negedge clk); #1 load0 = 1'b0;
        repeat (7) @(negedge clk);
        chk("lol_lastbit", lb0, 1);
        #1 data0 = 8'h00; load0 = 1'b1;
        @(negedge clk);
        chk("lol_valid_nogap", sv0, 1);
        #1 load0 = 1'b0;
        repeat (12) @(negedge clk);
        chk("lol_stream",    log0[15:0], 16'hFF00);
        chk("lol_count",     nv0, 16);
        chk("lol_never_full", nrl0, 0);

        // Overflow: C3 shifting, 5A held, 77 offered while full.
        @(negedge clk); #1 clr(); data0 = 8'hC3; load0 = 1'b1;
        @(negedge clk); #1 data0 = 8'h5A;
        @(negedge clk);
        chk("ovf_full", rdy0, 0);
        #1 data0 = 8'h77;
        repeat (4) @(negedge clk);
        #1 load0 = 1'b0;
        repeat (20) @(negedge clk);
        chk("ovf_stream", log0, 32'h0000_C35A);
        chk("ovf_count",  nv0, 16);

        // Reset during 3rd bit of D0 with 12 held.
        @(negedge clk); #1 clr(); data0 = 8'hD0; load0 = 1'b1;
        @(negedge clk); #1 data0 = 8'h12;
        @(negedge clk); #1 load0 = 1'b0;
        @(negedge clk);
        chk("rmw_bit3", so0, 0);
        #1 rst = 1'b1;
        #1;
        chk("rmw_valid", sv0, 0);
        chk("rmw_ready", rdy0, 1);
        chk("rmw_last",  lb0, 0);
        chk("rmw_sout",  so0, 0);
        @(negedge clk); #1 rst = 1'b0; clr();
        repeat (15) @(negedge clk);
        chk("rmw_no_bits", nv0, 0);

        // LSB first, idle high: 0B emits 1,1,0,1,0,0,0,0.
        @(negedge clk); #1 clr(); data1 = 8'h0B; load1 = 1'b1;
        @(negedge clk); #1 load1 = 1'b0;
        repeat (10) @(negedge clk);
        chk("lsb_stream", log1[7:0], 8'hD0);
        chk("lsb_count",  nv1, 8);
        chk("lsb_idle",   so1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_seq_serializer
`default_nettype wire
